// File: rtl/acia_host.sv
// acia_host: command/response bus master for the CPU-side register port of a 6551 ACIA.
// Handles raw register reads/writes and status-polled TX/RX byte transfers.
// Optional feature: define ACIA_HOST_TIMEOUT_EN to bound the number of status polls
// per polled op to TIMEOUT_POLLS; otherwise polling continues indefinitely.
module acia_host #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned TIMEOUT_POLLS = 255
) (
    input  logic       PHI2,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic [1:0] CMD_RS,
    input  logic [7:0] CMD_DATA,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic       CS,
    output logic       RWN,
    output logic [1:0] RS,
    output logic [7:0] DATAOUT,
    input  logic [7:0] DATAIN
);

    // Elaboration-time guard on the legal parameter ranges.
    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15 || TIMEOUT_POLLS < 1 || TIMEOUT_POLLS > 65535)
    begin : g_bad_param
        $error("acia_host: parameter out of range");
    end

    localparam logic [3:0] LAST_CYCLE = 4'(ACCESS_CYCLES - 1);
    localparam logic [1:0] RS_DATA    = 2'b00;
    localparam logic [1:0] RS_STATUS  = 2'b01;

    // DONE is folded into RECOVER: the response pulse is issued in the final RECOVER cycle.
    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t     state;
    logic [1:0] op;          // latched CMD_OP; op[1] = polled, op[0] = read
    logic [7:0] data_lat;
    logic [3:0] cnt;         // cycles elapsed in the current access
    logic       data_phase;  // polled op has seen its flag and is on the data access
    logic       finish;      // current RECOVER is the last one of the command
    logic       flag;

    // TDRE (bit 4) for TX, RDRF (bit 3) for RX.
    assign flag = op[0] ? DATAIN[3] : DATAIN[4];

`ifdef ACIA_HOST_TIMEOUT_EN
    localparam logic [15:0] POLL_LIMIT = 16'(TIMEOUT_POLLS);
    logic [15:0] polls;
`else
    assign RSP_ERR = 1'b0;
`endif

    // Single FSM: all bus and response outputs are registered.
    always_ff @(posedge PHI2) begin
        if (RESET) begin
            state      <= IDLE;
            CMD_READY  <= 1'b0;
            CS         <= 1'b1;
            RWN        <= 1'b1;
            RS         <= 2'b00;
            DATAOUT    <= 8'h00;
            RSP_VALID  <= 1'b0;
            RSP_DATA   <= 8'h00;
            op         <= 2'b00;
            data_lat   <= 8'h00;
            cnt        <= 4'd0;
            data_phase <= 1'b0;
            finish     <= 1'b0;
`ifdef ACIA_HOST_TIMEOUT_EN
            RSP_ERR    <= 1'b0;
            polls      <= 16'd0;
`endif
        end else begin
            RSP_VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY  <= 1'b0;
                        op         <= CMD_OP;
                        data_lat   <= CMD_DATA;
                        cnt        <= 4'd0;
                        data_phase <= 1'b0;
                        finish     <= 1'b0;
`ifdef ACIA_HOST_TIMEOUT_EN
                        polls      <= 16'd0;
`endif
                        state      <= ACCESS;
                        CS         <= 1'b0;
                        if (CMD_OP[1]) begin
                            RS      <= RS_STATUS;
                            RWN     <= 1'b1;
                            DATAOUT <= 8'h00;
                        end else begin
                            RS      <= CMD_RS;
                            RWN     <= CMD_OP[0];
                            DATAOUT <= CMD_OP[0] ? 8'h00 : CMD_DATA;
                        end
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (cnt == LAST_CYCLE) begin
                        cnt     <= 4'd0;
                        CS      <= 1'b1;
                        RWN     <= 1'b1;
                        DATAOUT <= 8'h00;
                        state   <= RECOVER;
                        if (!op[1] || data_phase) begin
                            // Raw access or polled data access: respond now.
                            finish    <= 1'b1;
                            RSP_VALID <= 1'b1;
`ifdef ACIA_HOST_TIMEOUT_EN
                            RSP_ERR   <= 1'b0;
`endif
                            if (RWN) begin
                                RSP_DATA <= DATAIN;
                            end
                        end else if (flag) begin
                            data_phase <= 1'b1;
                            finish     <= 1'b0;
`ifdef ACIA_HOST_TIMEOUT_EN
                        end else if (polls + 16'd1 == POLL_LIMIT) begin
                            polls     <= polls + 16'd1;
                            finish    <= 1'b1;
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= 1'b1;
                            RSP_DATA  <= DATAIN;
                        end else begin
                            polls  <= polls + 16'd1;
                            finish <= 1'b0;
                        end
`else
                        end else begin
                            finish <= 1'b0;
                        end
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                RECOVER: begin
                    if (finish) begin
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                    end else begin
                        state <= ACCESS;
                        CS    <= 1'b0;
                        if (data_phase) begin
                            RS      <= RS_DATA;
                            RWN     <= op[0];
                            DATAOUT <= op[0] ? 8'h00 : data_lat;
                        end else begin
                            RS      <= RS_STATUS;
                            RWN     <= 1'b1;
                            DATAOUT <= 8'h00;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    CS    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/acia_host.md
Name: acia_host

Overview:
- Synchronous bus master that drives the CPU-side register interface of the 6551 ACIA from a simple command/response stream.
- Sits between a controller (sequencer, soft-core glue, test harness) and the ACIA's CS/RWN/RS/DATAIN/DATAOUT pins.
- Performs raw register reads/writes, plus status-polled TX and RX byte transfers.

Parameters:
- ACCESS_CYCLES, 2, PHI2 cycles CS is held low per register access; legal range 1..15.
- TIMEOUT_POLLS, 255, maximum status reads per polled op; only used when ACIA_HOST_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- PHI2  in  1  system clock; all logic is rising-edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  host can accept a command.
- CMD_OP  in  2  00 raw write, 01 raw read, 10 polled TX, 11 polled RX.
- CMD_RS  in  2  register select for raw ops; ignored for polled ops.
- CMD_DATA  in  8  write data for raw write and polled TX.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_DATA  out  8  read data (raw read, polled RX) or last status (timeout).
- RSP_ERR  out  1  polled op timed out; qualified by RSP_VALID.
- CS  out  1  ACIA chip select, active-low.
- RWN  out  1  1 = read, 0 = write.
- RS  out  2  ACIA register select.
- DATAOUT  out  8  to ACIA DATAIN.
- DATAIN  in  8  from ACIA DATAOUT.

Behaviour:
- Reset (RESET=1 at an edge):
  - CS=1, RWN=1, RS=00, DATAOUT=00, RSP_VALID=0, RSP_DATA=00, RSP_ERR=0, CMD_READY=0.
  - CMD_READY rises in the first cycle after RESET deasserts.
- States: IDLE, ACCESS, RECOVER, DONE.
- IDLE:
  - CMD_READY=1; the command is accepted on the edge where CMD_VALID && CMD_READY.
  - On accept, CMD_OP, CMD_RS and CMD_DATA are latched and the state goes to ACCESS.
  - Inputs are not sampled again until the command completes.
- ACCESS (lasts exactly ACCESS_CYCLES cycles):
  - CS=0, RS and RWN held stable.
  - Write: DATAOUT driven with the latched byte for the whole access.
  - Read: DATAOUT=00, and DATAIN is sampled on the final ACCESS cycle edge.
- RECOVER (1 cycle):
  - CS=1, RWN=1, DATAOUT=00; decides the next step.
- Raw op timing, accepted at edge t:
  - CS low for cycles t+1..t+ACCESS_CYCLES.
  - RECOVER at t+ACCESS_CYCLES+1 with RSP_VALID=1.
  - CMD_READY=1 again the following cycle.
  - Total ACCESS_CYCLES+2 cycles command-to-ready.
- Polled TX:
  - Status read (RS=01, RWN=1).
  - If bit 4 (TDRE)=0: RECOVER, then re-poll.
  - If TDRE=1: RECOVER, then data write (RS=00, RWN=0, CMD_DATA), then respond as a raw op.
- Polled RX:
  - Same polling loop on status bit 3 (RDRF).
  - When set: data read at RS=00; RSP_DATA = byte read.
- Minimum latencies: polled op = 2*(ACCESS_CYCLES+1)+1 cycles to ready. Each extra poll adds ACCESS_CYCLES+1.
- Bus rules:
  - CS is never low in two consecutive accesses without an intervening CS=1 cycle.
  - RS and RWN change only while CS=1.
- DONE:
  - Merged with RECOVER: RSP_VALID is high in the final RECOVER cycle only.
  - RSP_DATA and RSP_ERR hold until the next RSP_VALID.
- No response back-pressure; the consumer must take RSP_* in the pulse cycle.
- RESET mid-operation:
  - CS=1 and all outputs at reset values on the next cycle.
  - No RSP_VALID is issued for the aborted command.
- CMD_VALID held with CMD_READY=0 is ignored; there is no queueing.

Optional Feature:
- Macro: ACIA_HOST_TIMEOUT_EN.
- Defined:
  - A 16-bit poll counter clears on accept and increments per status read.
  - When a status read with the flag still clear makes the count equal TIMEOUT_POLLS, the op ends in that RECOVER cycle with RSP_VALID=1, RSP_ERR=1, RSP_DATA=last status byte.
  - No data access is performed.
- Undefined:
  - Polling continues indefinitely.
  - RSP_ERR is tied 0 and no counter exists.

Test Plan (ACCESS_CYCLES=2):
- Raw write CMD_OP=00, RS=11, DATA=1E → CS low 2 cycles with RS=11, RWN=0, DATAOUT=1E; RSP_VALID in cycle 3; CMD_READY in cycle 4.
- Raw read CMD_OP=01, RS=01, model DATAIN=10 → RSP_DATA=10, RSP_ERR=0, RWN=1 throughout the access.
- Polled TX DATA=A5, status returns 00,00,10 → three status reads each separated by CS=1, then one write RS=00 DATAOUT=A5; RSP_VALID once.
- Polled RX, status 08 then data 5A → RSP_DATA=5A, exactly two accesses.
- With ACIA_HOST_TIMEOUT_EN, TIMEOUT_POLLS=3, polled RX, status always 00 → exactly 3 status reads, RSP_ERR=1, RSP_DATA=00, no RS=00 access.
- RESET asserted during the 2nd ACCESS cycle of a write → next cycle CS=1, DATAOUT=00, no RSP_VALID; CMD_READY=1 one cycle after RESET drops.
